// File: rtl/wave_gen_pkg.sv
// Shared encodings and constants for multi_wave_generator.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_DC     = 2'd3
  } wave_sel_e;

  localparam int unsigned PIPE_LATENCY = 32'd3;

endpackage

// File: rtl/multi_wave_generator_phase_accumulator.sv
// Stage S0: phase accumulator with restart and wrap/saturate overflow handling.
module phase_accumulator
  import wave_gen_pkg::*;
#(
  parameter int N_FRAC = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     strobe_i,
  input  logic                     sync_i,
  input  logic                     overflow_mode_i,
  input  logic signed [N_FRAC:0]   phase_i,
  output logic signed [N_FRAC:0]   acc_o,
  output logic                     valid_o
);

  localparam int W = N_FRAC + 1;
  localparam logic signed [W-1:0] MAX_V = {1'b0, {N_FRAC{1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {N_FRAC{1'b0}}};

  logic signed [W-1:0] acc_q, acc_d;
  logic                valid_q, valid_d;
  logic signed [W:0]   sum_s;
  logic                ovf_s;

  // One guard bit exposes overflow as a mismatch between the top two sum bits.
  always_comb begin
    sum_s   = {acc_q[W-1], acc_q} + {phase_i[W-1], phase_i};
    ovf_s   = sum_s[W] ^ sum_s[W-1];
    acc_d   = acc_q;
    valid_d = 1'b0;
    if (strobe_i) begin
      valid_d = 1'b1;
      if (sync_i) begin
        acc_d = phase_i;
      end else if (ovf_s && overflow_mode_i) begin
        acc_d = sum_s[W] ? MIN_V : MAX_V;
      end else begin
        acc_d = sum_s[W-1:0];
      end
    end else if (sync_i) begin
      acc_d = '0;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

  assign acc_o   = acc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/multi_wave_generator.sv
// Three-stage waveform generator (accumulate, shape, scale).
// Optional amplitude scaling enabled by defining WAVE_GEN_AMPLITUDE_SCALE_EN.
module multi_wave_generator
  import wave_gen_pkg::*;
#(
  parameter int N_FRAC = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   phase_i,
  input  logic signed [N_FRAC:0]   duty_i,
  input  logic signed [N_FRAC:0]   amplitude_i,
  input  logic [1:0]               wave_sel_i,
  input  logic                     overflow_mode_i,
  input  logic                     sync_i,
  input  logic                     next_data_strobe_i,
  output logic signed [N_FRAC:0]   data_o,
  output logic                     data_out_valid_strobe_o
);

  localparam int W = N_FRAC + 1;
  localparam logic signed [W-1:0] MAX_V = {1'b0, {N_FRAC{1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {N_FRAC{1'b0}}};
  localparam logic signed [W-1:0] NEG_MAX_V = {1'b1, {(N_FRAC-1){1'b0}}, 1'b1};

  logic signed [W-1:0] acc_s0_s;
  logic                valid_s0_s;
  logic signed [W-1:0] duty_s0_q, duty_s0_d;
  wave_sel_e           sel_s0_q, sel_s0_d;
  logic signed [W-1:0] shaped_q, shaped_d;
  logic                valid_s1_q, valid_s1_d;
  logic signed [W-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [W-1:0]        tri_t_s;
  logic [W:0]          tri_wide_s;
  logic signed [W-1:0] scaled_s;

  phase_accumulator #(.N_FRAC(N_FRAC)) u_acc (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .strobe_i       (next_data_strobe_i),
    .sync_i         (sync_i),
    .overflow_mode_i(overflow_mode_i),
    .phase_i        (phase_i),
    .acc_o          (acc_s0_s),
    .valid_o        (valid_s0_s)
  );

`ifdef WAVE_GEN_AMPLITUDE_SCALE_EN
  logic signed [W-1:0]   amp_s0_q, amp_s0_d, amp_s1_q, amp_s1_d;
  logic signed [2*W-1:0] prod_s, shifted_s;

  // Full-width product, arithmetic shift, then clamp if the upper bits disagree.
  always_comb begin
    amp_s0_d  = next_data_strobe_i ? amplitude_i : amp_s0_q;
    amp_s1_d  = valid_s0_s ? amp_s0_q : amp_s1_q;
    prod_s    = $signed({{W{shaped_q[W-1]}}, shaped_q}) * $signed({{W{amp_s1_q[W-1]}}, amp_s1_q});
    shifted_s = prod_s >>> N_FRAC;
    if (shifted_s[2*W-1:W-1] == {(W+1){shifted_s[2*W-1]}}) begin
      scaled_s = shifted_s[W-1:0];
    end else begin
      scaled_s = shifted_s[2*W-1] ? MIN_V : MAX_V;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      amp_s0_q <= '0;
      amp_s1_q <= '0;
    end else begin
      amp_s0_q <= amp_s0_d;
      amp_s1_q <= amp_s1_d;
    end
  end
`else
  logic amp_unused_s;
  assign amp_unused_s = ^amplitude_i;

  always_comb begin
    scaled_s = shaped_q;
  end
`endif

  always_comb begin
    if (next_data_strobe_i) begin
      duty_s0_d = duty_i;
      sel_s0_d  = wave_sel_e'(wave_sel_i);
    end else begin
      duty_s0_d = duty_s0_q;
      sel_s0_d  = sel_s0_q;
    end
  end

  // Triangle folds negative phase with ~acc so the ramp spans 0..MAX without overflow.
  always_comb begin
    tri_t_s    = acc_s0_s[W-1] ? ~acc_s0_s : acc_s0_s;
    tri_wide_s = {tri_t_s, 1'b0} - {2'b00, MAX_V[W-2:0]};
    valid_s1_d = valid_s0_s;
    shaped_d   = shaped_q;
    if (valid_s0_s) begin
      case (sel_s0_q)
        WAVE_SAW:    shaped_d = acc_s0_s;
        WAVE_TRI:    shaped_d = tri_wide_s[W-1:0];
        WAVE_SQUARE: shaped_d = (acc_s0_s >= duty_s0_q) ? MAX_V : NEG_MAX_V;
        WAVE_DC:     shaped_d = duty_s0_q;
        default:     shaped_d = duty_s0_q;
      endcase
    end else begin
      shaped_d = shaped_q;
    end
  end

  always_comb begin
    valid_d = valid_s1_q;
    if (valid_s1_q) begin
      data_d = scaled_s;
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_s0_q  <= '0;
      sel_s0_q   <= WAVE_SAW;
      shaped_q   <= '0;
      valid_s1_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      duty_s0_q  <= duty_s0_d;
      sel_s0_q   <= sel_s0_d;
      shaped_q   <= shaped_d;
      valid_s1_q <= valid_s1_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign data_o                  = data_q;
  assign data_out_valid_strobe_o = valid_q;

endmodule

// File: tb/tb_multi_wave_generator.sv
// Directed self-checking bench for multi_wave_generator (N_FRAC = 7).
module tb_multi_wave_generator;
  import wave_gen_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic signed [7:0] phase_i, duty_i, amplitude_i;
  logic [1:0]        wave_sel_i;
  logic              overflow_mode_i, sync_i, next_data_strobe_i;
  logic signed [7:0] data_o;
  logic              data_out_valid_strobe_o;

  int n_tests = 0;
  int n_fail  = 0;

  multi_wave_generator #(.N_FRAC(7)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .phase_i                (phase_i),
    .duty_i                 (duty_i),
    .amplitude_i            (amplitude_i),
    .wave_sel_i             (wave_sel_i),
    .overflow_mode_i        (overflow_mode_i),
    .sync_i                 (sync_i),
    .next_data_strobe_i     (next_data_strobe_i),
    .data_o                 (data_o),
    .data_out_valid_strobe_o(data_out_valid_strobe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_out(input int shaped, input int amp);
`ifdef WAVE_GEN_AMPLITUDE_SCALE_EN
    int p;
    p = (shaped * amp) >>> 7;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p;
`else
    return shaped;
`endif
  endfunction

  // One strobe; in-flight inputs are scrambled to prove they were captured.
  task automatic one(input string tag, input int phase, input int sel, input int duty,
                     input int amp, input bit mode, input bit sync, input int exp);
    phase_i = 8'(phase); wave_sel_i = 2'(sel); duty_i = 8'(duty);
    amplitude_i = 8'(amp); overflow_mode_i = mode; sync_i = sync;
    next_data_strobe_i = 1'b1;
    tick();
    next_data_strobe_i = 1'b0; sync_i = 1'b0;
    wave_sel_i = 2'd3; duty_i = 8'sd99; amplitude_i = 8'sd0; phase_i = 8'sd3;
    check({tag, "_v1"}, int'(data_out_valid_strobe_o), 0);
    tick();
    check({tag, "_v2"}, int'(data_out_valid_strobe_o), 0);
    tick();
    check({tag, "_v3"}, int'(data_out_valid_strobe_o), 1);
    check({tag, "_data"}, int'(data_o), exp_out(exp, amp));
    tick();
    check({tag, "_v4"}, int'(data_out_valid_strobe_o), 0);
    check({tag, "_hold"}, int'(data_o), exp_out(exp, amp));
  endtask

  initial begin
    rst_i = 1'b1; phase_i = '0; duty_i = '0; amplitude_i = '0; wave_sel_i = 2'd0;
    overflow_mode_i = 1'b0; sync_i = 1'b0; next_data_strobe_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    check("rst_data", int'(data_o), 0);
    check("rst_valid", int'(data_out_valid_strobe_o), 0);
    check("latency_const", int'(PIPE_LATENCY), 3);

    // Four back-to-back sawtooth strobes: pulses in cycles 3..6.
    phase_i = 8'sd16; wave_sel_i = 2'(WAVE_SAW); amplitude_i = 8'sd127;
    next_data_strobe_i = 1'b1;
    tick(); check("b2b_c1", int'(data_out_valid_strobe_o), 0);
    tick(); check("b2b_c2", int'(data_out_valid_strobe_o), 0);
    tick(); check("b2b_c3v", int'(data_out_valid_strobe_o), 1);
    check("b2b_c3d", int'(data_o), exp_out(16, 127));
    tick(); check("b2b_c4v", int'(data_out_valid_strobe_o), 1);
    check("b2b_c4d", int'(data_o), exp_out(32, 127));
    next_data_strobe_i = 1'b0;
    tick(); check("b2b_c5v", int'(data_out_valid_strobe_o), 1);
    check("b2b_c5d", int'(data_o), exp_out(48, 127));
    tick(); check("b2b_c6v", int'(data_out_valid_strobe_o), 1);
    check("b2b_c6d", int'(data_o), exp_out(64, 127));
    tick(); check("b2b_c7v", int'(data_out_valid_strobe_o), 0);
    check("b2b_c7d", int'(data_o), exp_out(64, 127));

    // Overflow: wrap then saturate, both directions.
    one("acc112", 48, 0, 0, 127, 1'b0, 1'b0, 112);
    one("wrap_pos", 32, 0, 0, 127, 1'b0, 1'b0, -112);
    one("sync112", 112, 0, 0, 127, 1'b1, 1'b1, 112);
    one("sat_pos", 32, 0, 0, 127, 1'b1, 1'b0, 127);
    one("sat_hold", 32, 0, 0, 127, 1'b1, 1'b0, 127);
    one("sync_m128", -128, 0, 0, 127, 1'b1, 1'b1, -128);
    one("sat_neg", -1, 0, 0, 127, 1'b1, 1'b0, -128);
    one("wrap_neg", -1, 0, 0, 127, 1'b0, 1'b0, 127);

    // Triangle, square, DC.
    one("tri_0", 0, 1, 0, 127, 1'b0, 1'b1, -127);
    one("tri_64", 64, 1, 0, 127, 1'b0, 1'b0, 1);
    one("tri_m1", -1, 1, 0, 127, 1'b0, 1'b1, -127);
    one("tri_m128", -128, 1, 0, 127, 1'b0, 1'b1, 127);
    one("sq_m1", -1, 2, 0, 127, 1'b0, 1'b1, -127);
    one("sq_0", 0, 2, 0, 127, 1'b0, 1'b1, 127);
    one("dc_64", 0, 3, 64, 64, 1'b0, 1'b0, 64);
    one("dc_m128", 0, 3, -128, -128, 1'b0, 1'b0, -128);
    one("sync_5", 5, 0, 0, 127, 1'b0, 1'b1, 5);

    // Reset one cycle after a strobe drops the sample.
    phase_i = 8'sd20; wave_sel_i = 2'd0; next_data_strobe_i = 1'b1;
    tick();
    next_data_strobe_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_v", int'(data_out_valid_strobe_o), 0);
      check("rst_mid_d", int'(data_o), 0);
      tick();
    end

    // Reset dominates strobe and sync in the same cycle.
    phase_i = 8'sd40; next_data_strobe_i = 1'b1; sync_i = 1'b1; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; next_data_strobe_i = 1'b0; sync_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_dom_v", int'(data_out_valid_strobe_o), 0);
      tick();
    end
    one("first_after_rst", 7, 0, 0, 127, 1'b0, 1'b0, 7);

    // Sync alone clears acc without a pulse.
    one("pre_sync", 30, 0, 0, 127, 1'b0, 1'b0, 37);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sync_only_v", int'(data_out_valid_strobe_o), 0);
      tick();
    end
    one("after_sync", 9, 0, 0, 127, 1'b0, 1'b0, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_wave_generator.md
MULTI_WAVE_GENERATOR -- requirements
Module: multi_wave_generator

Interface
REQ-001 Parameter: N_FRAC, default 7, fractional bits; all data ports signed N_FRAC+1 bits (Q0.N_FRAC); MAX = 2^N_FRAC-1.
REQ-002 Clock and reset: one clock, clk_i; reset is synchronous and active-high, rst_i.
REQ-003 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 phase_i  in  N_FRAC+1 signed  accumulator addend per sample.
REQ-006 duty_i  in  N_FRAC+1 signed  square threshold; DC level when wave_sel_i=3.
REQ-007 amplitude_i  in  N_FRAC+1 signed  output gain.
REQ-008 wave_sel_i  in  2  0 sawtooth, 1 triangle, 2 square, 3 DC.
REQ-009 overflow_mode_i  in  1  0 wrap, 1 saturate.
REQ-010 sync_i  in  1  phase restart.
REQ-011 next_data_strobe_i  in  1  request one output sample.
REQ-012 data_o  out  N_FRAC+1 signed  registered sample.
REQ-013 data_out_valid_strobe_o  out  1  single-cycle pulse, data_o valid.

Function
REQ-014 Three-stage pipeline: S0 accumulate, S1 shape, S2 scale; data_out_valid_strobe_o pulses exactly 3 cycles after the cycle next_data_strobe_i is sampled high.
REQ-015 Strobes accepted every cycle, no stall; N strobes yield N output pulses in order.
REQ-016 phase_i, duty_i, amplitude_i, wave_sel_i sampled in the strobe cycle and carried down the pipeline; later changes do not affect in-flight samples.
REQ-017 S0, strobe without sync_i: acc <= acc + phase_i; without strobe acc holds.
REQ-018 overflow_mode_i=0: two's-complement wrap (MAX+1 -> -(MAX+1)).
REQ-019 overflow_mode_i=1: clamp to MAX on positive overflow, to -(MAX+1) on negative overflow.
REQ-020 sync_i with strobe: acc <= phase_i (restart from zero, then add); sync_i without strobe: acc <= 0, no output pulse.
REQ-021 S1 sawtooth: acc.
REQ-022 S1 triangle: t = acc<0 ? ~acc : acc (0..MAX); tri = 2t - MAX, range -MAX..MAX, no overflow.
REQ-023 S1 square: acc >= duty_i ? MAX : -MAX.
REQ-024 S1 DC: duty_i.
REQ-025 S2 per REQ-034/035; data_o holds last value between pulses.

Reset
REQ-026 rst_i high: acc, all pipeline registers, data_o <= 0; data_out_valid_strobe_o <= 0.
REQ-027 Reset mid-operation drops every in-flight sample; no pulse emitted for strobes preceding reset.
REQ-028 rst_i dominates next_data_strobe_i and sync_i in the same cycle.
REQ-029 First strobe after reset produces acc = phase_i.

Configuration
REQ-030 Macro WAVE_GEN_AMPLITUDE_SCALE_EN selects amplitude scaling.
REQ-031 Defined: S2 computes (shaped * amplitude_i) >>> N_FRAC (arithmetic), saturated to [-(MAX+1), MAX].
REQ-032 Undefined: S2 is a plain register of the shaped value; amplitude_i ignored; no multiplier synthesised.
REQ-033 Latency 3 cycles in both builds.
REQ-034 Scaling product: full 2*(N_FRAC+1)-bit signed, shifted before saturation.
REQ-035 Only (-(MAX+1))*(-(MAX+1)) can saturate; result MAX.

Structure
REQ-036 Package wave_gen_pkg: wave_sel encodings WAVE_SAW/WAVE_TRI/WAVE_SQUARE/WAVE_DC, pipeline latency constant 3.
REQ-037 One sub-module phase_accumulator (S0: addend, sync, overflow mode, strobe-in, value + valid strobe out); shaping and scaling inline.

Verification (N_FRAC=7)
REQ-038 Reset, then phase_i=16, wave_sel=0, 4 strobes back-to-back -> pulses at cycles 3..6, data_o 16,32,48,64.
REQ-039 acc=112, phase_i=32: mode 0 -> -112; mode 1 -> 127, then holds 127 on further strobes.
REQ-040 wave_sel=1, acc 0/64/-1/-128 -> data_o -127/1/-127/127; wave_sel=2, duty_i=0, acc -1 -> -127, acc 0 -> 127.
REQ-041 Scale build: DC duty_i=64, amplitude_i=64 -> 32; duty_i=-128, amplitude_i=-128 -> 127; non-scale build same stimulus -> 64, -128.
REQ-042 sync_i+strobe with phase_i=5 -> 5; rst_i 1 cycle after a strobe -> no pulse, data_o 0; sync_i alone -> no pulse, next strobe -> phase_i.
